// File: rtl/chainreset_supervisor.sv
// Supervises the chain-reset sequencer: kicks the chain, timestamps each step's completion,
// latches sticky error flags and re-kicks after failures up to a bounded retry count.
module chainreset_supervisor #(
  parameter int NSTEP    = 3,
  parameter int TSW      = 32,
  parameter int MAXRETRY = 3,
  parameter int RETRYGAP = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NSTEP-1:0]     done,
  input  logic [NSTEP-1:0]     donestrobe,
  input  logic [NSTEP-1:0]     error,
  output logic                 kick,
  output logic                 busy,
  output logic                 alldone,
  output logic                 failed,
  output logic [3:0]           retrycnt,
  output logic [NSTEP-1:0]     errmask,
  output logic [NSTEP-1:0]     stepseen,
  output logic [NSTEP*TSW-1:0] stepts
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KICK,
    S_RUN,
    S_GAP,
    S_DONE,
    S_FAIL
  } state_t;

  localparam logic [3:0]     MAXR     = 4'(MAXRETRY);
  localparam logic [15:0]    GAP_LAST = 16'(RETRYGAP - 1);
  localparam logic [TSW-1:0] TS_ONE   = TSW'(1);

  state_t           state_reg, state_next;
  logic [TSW-1:0]   elapsed_reg, elapsed_next;
  logic [15:0]      gap_reg, gap_next;
  logic [3:0]       retry_reg, retry_next;
  logic [NSTEP-1:0] errmask_reg, errmask_next;
  logic [NSTEP-1:0] seen_reg, seen_next;
  logic [NSTEP-1:0] error_q_reg;
  logic [NSTEP-1:0] erise;
  logic [NSTEP-1:0] cap;
  logic [TSW-1:0]   ts_reg [NSTEP];
  logic [TSW-1:0]   ts_next [NSTEP];
  logic             kick_reg, busy_reg, alldone_reg, failed_reg;

  // done is a status level only; control relies on donestrobe
  logic unused_done;
  assign unused_done = ^done;

  assign erise = error & ~error_q_reg;

  always_comb begin
    state_next   = state_reg;
    elapsed_next = elapsed_reg;
    gap_next     = gap_reg;
    retry_next   = retry_reg;
    errmask_next = errmask_reg;
    seen_next    = seen_reg;
    ts_next      = ts_reg;
    cap          = '0;
    case (state_reg)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) begin
          errmask_next = '0;
          retry_next   = '0;
          seen_next    = '0;
          ts_next      = '{default: '0};
          state_next   = S_KICK;
        end
      end
      S_KICK: begin
        elapsed_next = TS_ONE;
        seen_next    = '0;
        ts_next      = '{default: '0};
        errmask_next = errmask_reg | erise;
        state_next   = S_RUN;
      end
      S_RUN: begin
        if (elapsed_reg != '1) elapsed_next = elapsed_reg + TS_ONE;
        cap       = donestrobe & ~seen_reg;
        seen_next = seen_reg | cap;
        for (int i = 0; i < NSTEP; i++) begin
          if (cap[i]) ts_next[i] = elapsed_reg;
        end
        // an error edge wins over a coincident final strobe; that strobe is still timestamped
        if (erise != '0) begin
          errmask_next = errmask_reg | erise;
          if (retry_reg < MAXR) begin
            retry_next = retry_reg + 4'd1;
            gap_next   = '0;
            state_next = S_GAP;
          end else begin
            state_next = S_FAIL;
          end
        end else if (&seen_next) begin
          state_next = S_DONE;
        end
      end
      S_GAP: begin
        errmask_next = errmask_reg | erise;
        if (gap_reg == GAP_LAST) state_next = S_KICK;
        else                     gap_next   = gap_reg + 16'd1;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      elapsed_reg <= '0;
      gap_reg     <= '0;
      retry_reg   <= '0;
      errmask_reg <= '0;
      seen_reg    <= '0;
      error_q_reg <= '0;
      ts_reg      <= '{default: '0};
      kick_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      alldone_reg <= 1'b0;
      failed_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      elapsed_reg <= elapsed_next;
      gap_reg     <= gap_next;
      retry_reg   <= retry_next;
      errmask_reg <= errmask_next;
      seen_reg    <= seen_next;
      error_q_reg <= error;
      ts_reg      <= ts_next;
      kick_reg    <= (state_next == S_KICK);
      busy_reg    <= (state_next == S_KICK) || (state_next == S_RUN) || (state_next == S_GAP);
      alldone_reg <= (state_next == S_DONE);
      failed_reg  <= (state_next == S_FAIL);
    end
  end

  assign kick     = kick_reg;
  assign busy     = busy_reg;
  assign alldone  = alldone_reg;
  assign failed   = failed_reg;
  assign retrycnt = retry_reg;
  assign errmask  = errmask_reg;
  assign stepseen = seen_reg;

  generate
    for (genvar gi = 0; gi < NSTEP; gi++) begin : g_ts
      assign stepts[gi*TSW +: TSW] = ts_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_chainreset_supervisor.sv
// Directed bench for chainreset_supervisor; a TSW=8 copy on the same inputs shows timestamp saturation.
module tb_chainreset_supervisor;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  done, donestrobe, error;
  logic        kick, busy, alldone, failed;
  logic [3:0]  retrycnt;
  logic [2:0]  errmask, stepseen;
  logic [95:0] stepts;
  logic        kick8, busy8, alldone8, failed8;
  logic [3:0]  retrycnt8;
  logic [2:0]  errmask8, stepseen8;
  logic [23:0] stepts8;

  int vectors = 0, miscompares = 0, cyc = 0, kicks = 0;
  int k, kb, kc;

  chainreset_supervisor #(.NSTEP(3), .TSW(32), .MAXRETRY(3), .RETRYGAP(16)) dut (
    .clk(clk), .reset(reset), .start(start), .done(done), .donestrobe(donestrobe),
    .error(error), .kick(kick), .busy(busy), .alldone(alldone), .failed(failed),
    .retrycnt(retrycnt), .errmask(errmask), .stepseen(stepseen), .stepts(stepts)
  );

  chainreset_supervisor #(.NSTEP(3), .TSW(8), .MAXRETRY(3), .RETRYGAP(16)) dut8 (
    .clk(clk), .reset(reset), .start(start), .done(done), .donestrobe(donestrobe),
    .error(error), .kick(kick8), .busy(busy8), .alldone(alldone8), .failed(failed8),
    .retrycnt(retrycnt8), .errmask(errmask8), .stepseen(stepseen8), .stepts(stepts8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (kick === 1'b1) kicks <= kicks + 1;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic at(input int target);
    while (cyc < target) tick(1);
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input int i, input int target);
    at(target);
    donestrobe[i] = 1'b1;
    tick(1);
    donestrobe[i] = 1'b0;
  endtask

  task automatic accept_start(output int kcyc);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    kcyc = cyc;
    check("start_kick", kick, 1);
  endtask

  task automatic wait_kick(output int kcyc);
    int n;
    n = 0;
    while (kick !== 1'b1 && n < 200) begin
      tick(1);
      n++;
    end
    check("kick_wait", kick, 1);
    kcyc = cyc;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_kick"}, kick, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_alldone"}, alldone, 0);
    check({tag, "_failed"}, failed, 0);
    check({tag, "_retry"}, retrycnt, 0);
    check({tag, "_errmask"}, errmask, 0);
    check({tag, "_seen"}, stepseen, 0);
    check({tag, "_stepts"}, stepts, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; done = '0; donestrobe = '0; error = '0;
    tick(3);
    check_zero("reset");
    $display("reset: outputs checked at cycle %0d", cyc);
    reset = 1'b0;

    // clean run, with an ignored start in RUN and a duplicate strobe
    at(10);
    check("pre_kick", kick, 0);
    accept_start(k);
    check("kick_cycle11_busy", busy, 1);
    tick(1);
    check("kick_one_cycle", kick, 0);
    strobe(0, k + 600);
    check("clean_ts0", stepts[31:0], 600);
    check("clean_seen0", stepseen, 3'b001);
    at(k + 700);
    start = 1'b1; tick(1); start = 1'b0;
    strobe(0, k + 800);
    check("dup_ts0", stepts[31:0], 600);
    strobe(1, k + 1100);
    at(k + 2400);
    check("clean_not_done_early", alldone, 0);
    donestrobe[2] = 1'b1; tick(1); donestrobe[2] = 1'b0;
    check("clean_alldone", alldone, 1);
    check("clean_busy", busy, 0);
    check("clean_stepts", stepts, {32'd2400, 32'd1100, 32'd600});
    check("clean_retry", retrycnt, 0);
    check("clean_errmask", errmask, 0);
    check("clean_kicks", kicks, 1);
    check("sat_stepts8", stepts8, {8'd255, 8'd255, 8'd255});
    check("sat_alldone8", alldone8, 1);
    $display("clean run: kick at %0d, alldone at %0d", k, cyc);

    // single retry with an error edge 300 cycles after kick
    tick(3);
    check("done_hold", alldone, 1);
    kb = kicks;
    accept_start(k);
    check("retry_seen_clr", stepseen, 0);
    check("retry_ts_clr", stepts, 0);
    at(k + 300);
    error[1] = 1'b1;
    tick(1);
    check("retry_gap_busy", busy, 1);
    check("retry_cnt1", retrycnt, 1);
    check("retry_errmask", errmask, 3'b010);
    at(k + 305);
    error[1] = 1'b0;
    at(k + 308);
    start = 1'b1; tick(1); start = 1'b0;
    at(k + 316);
    check("retry_no_early_kick", kick, 0);
    tick(1);
    check("retry_kick_at_317", kick, 1);
    kc = cyc;
    strobe(0, kc + 50);
    strobe(1, kc + 60);
    strobe(2, kc + 70);
    check("retry_alldone", alldone, 1);
    check("retry_cnt_final", retrycnt, 1);
    check("retry_errmask_final", errmask, 3'b010);
    check("retry_stepts", stepts, {32'd70, 32'd60, 32'd50});
    check("retry_kicks", kicks - kb, 2);
    $display("single retry: kicks at %0d and %0d", k, kc);

    // error edge with final strobe, then error held across the re-kick
    kb = kicks;
    accept_start(k);
    strobe(0, k + 10);
    strobe(1, k + 20);
    at(k + 30);
    donestrobe[2] = 1'b1; error[2] = 1'b1;
    tick(1);
    donestrobe[2] = 1'b0;
    check("simul_gap_busy", busy, 1);
    check("simul_not_done", alldone, 0);
    check("simul_seen", stepseen, 3'b111);
    check("simul_ts2", stepts[95:64], 30);
    check("simul_retry", retrycnt, 1);
    check("simul_errmask", errmask, 3'b100);
    at(k + 47);
    check("simul_rekick", kick, 1);
    kc = cyc;
    strobe(0, kc + 5);
    strobe(1, kc + 6);
    strobe(2, kc + 7);
    check("held_alldone", alldone, 1);
    check("held_no_retry", retrycnt, 1);
    check("held_kicks", kicks - kb, 2);
    error[2] = 1'b0;
    $display("simultaneous events: alldone at %0d", cyc);

    // retry exhaustion: error on every attempt
    kb = kicks;
    start = 1'b1; tick(1); start = 1'b0;
    for (int a = 0; a < 4; a++) begin
      wait_kick(kc);
      at(kc + 20);
      error[0] = 1'b1; tick(1); error[0] = 1'b0;
    end
    check("exh_failed", failed, 1);
    check("exh_busy", busy, 0);
    check("exh_retry", retrycnt, 3);
    check("exh_errmask", errmask, 3'b001);
    tick(100);
    check("exh_kicks", kicks - kb, 4);
    check("exh_failed_hold", failed, 1);
    $display("retry exhaustion: failed at cycle %0d", cyc);

    // reset during RUN
    kb = kicks;
    accept_start(k);
    strobe(0, k + 10);
    at(k + 50);
    check("rrun_seen", stepseen, 3'b001);
    reset = 1'b1; tick(1); reset = 1'b0;
    check_zero("rrun");
    tick(40);
    check("rrun_kicks", kicks - kb, 1);
    check("rrun_idle", busy, 0);
    $display("reset in RUN at cycle %0d", k + 50);

    // reset during GAP
    kb = kicks;
    accept_start(k);
    at(k + 10);
    error[1] = 1'b1; tick(1); error[1] = 1'b0;
    at(k + 15);
    check("rgap_busy", busy, 1);
    check("rgap_retry", retrycnt, 1);
    reset = 1'b1; tick(1); reset = 1'b0;
    check_zero("rgap");
    tick(40);
    check("rgap_kicks", kicks - kb, 1);
    check("rgap_idle", busy, 0);
    $display("reset in GAP at cycle %0d", k + 15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
